// File: rtl/check_redun_pkg.sv
// Shared sizes and FSM state encodings for the receive-side redundancy checker.
// NS_REDUN_ERR_CNT_EN enables the dropped-message counter.
package check_redun_pkg;

  localparam int NS_REDUN_SIZE   = 4;
  localparam int NS_ADDRESS_SIZE = 4;
  localparam int NS_DATA_SIZE    = 4;
  localparam int NS_FULL_MSG_SZ  =
    2 * NS_ADDRESS_SIZE + NS_DATA_SIZE;

  typedef enum logic [2:0] {
    NS_CHKR_ST_IDLE   = 3'd0,
    NS_CHKR_ST_CHK    = 3'd1,
    NS_CHKR_ST_SND    = 3'd2,
    NS_CHKR_ST_SND_WT = 3'd3,
    NS_CHKR_ST_DROP   = 3'd4,
    NS_CHKR_ST_RLS    = 3'd5
  } chkr_st_t;

endpackage

// File: rtl/check_redun_redun_gen.sv
// Combinational redundancy generator: one NAND-reduced slice per bit.
// The top bit also absorbs the remainder bits of the message.
module redun_gen #(
  parameter int RSZ = 4,
  parameter int MSZ = 12
) (
  input  logic [MSZ-1:0] full,
  output logic [RSZ-1:0] red
);

  localparam int PART_SZ = MSZ / RSZ;

  // Equal-size slices for the lower bits
  for (genvar ii = 0; ii < RSZ - 1; ii++) begin : g_part
    assign red[ii] =
      ~&full[(ii+1)*PART_SZ-1 -: PART_SZ];
  end

  // Top slice runs to the message MSB
  assign red[RSZ-1] =
    ~&full[MSZ-1 : (RSZ-1)*PART_SZ];

endmodule

// File: rtl/check_redun.sv
// Redundancy checker: buffers a message, checks it, forwards or drops.
// NS_REDUN_ERR_CNT_EN builds the saturating dropped-message counter.
module check_redun
  import check_redun_pkg::*;
#(
  parameter int RSZ  = NS_REDUN_SIZE,
  parameter int ASZ  = NS_ADDRESS_SIZE,
  parameter int DSZ  = NS_DATA_SIZE,
  parameter int ECSZ = 8
) (
  input  logic            i_clk,
  input  logic            reset,
  input  logic [ASZ-1:0]  rcv0_src,
  input  logic [ASZ-1:0]  rcv0_dst,
  input  logic [DSZ-1:0]  rcv0_dat,
  input  logic [RSZ-1:0]  rcv0_red,
  input  logic            rcv0_req,
  output logic            rcv0_ack,
  output logic [ASZ-1:0]  snd0_src,
  output logic [ASZ-1:0]  snd0_dst,
  output logic [DSZ-1:0]  snd0_dat,
  output logic [RSZ-1:0]  snd0_red,
  output logic            snd0_req,
  input  logic            snd0_ack,
  output logic            redun_err,
  output logic [ECSZ-1:0] err_cnt
);

  localparam int MSZ = 2 * ASZ + DSZ;

  chkr_st_t st_q;
  chkr_st_t st_n;

  logic [ASZ-1:0] src_q;
  logic [ASZ-1:0] dst_q;
  logic [DSZ-1:0] dat_q;
  logic [RSZ-1:0] red_q;
  logic [RSZ-1:0] red_calc;
  logic           match;
  logic           drop_ev;

  redun_gen #(
    .RSZ (RSZ),
    .MSZ (MSZ)
  ) u_gen (
    .full ({src_q, dst_q, dat_q}),
    .red  (red_calc)
  );

  assign match   = (red_calc == red_q);
  assign drop_ev = (st_q == NS_CHKR_ST_CHK) && !match;

  assign snd0_src = src_q;
  assign snd0_dst = dst_q;
  assign snd0_dat = dat_q;
  assign snd0_red = red_q;

  // State register
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) st_q <= NS_CHKR_ST_IDLE;
    else        st_q <= st_n;
  end

  // Next-state logic
  always_comb begin
    st_n = st_q;
    unique case (st_q)
      NS_CHKR_ST_IDLE:
        if (rcv0_req) st_n = NS_CHKR_ST_CHK;
      NS_CHKR_ST_CHK:
        st_n = match ? NS_CHKR_ST_SND
                     : NS_CHKR_ST_DROP;
      NS_CHKR_ST_SND:
        if (snd0_ack && snd0_req)
          st_n = NS_CHKR_ST_SND_WT;
      NS_CHKR_ST_SND_WT:
        if (!snd0_ack) st_n = NS_CHKR_ST_RLS;
      NS_CHKR_ST_DROP:
        st_n = NS_CHKR_ST_RLS;
      NS_CHKR_ST_RLS:
        if (!rcv0_req) st_n = NS_CHKR_ST_IDLE;
      default:
        st_n = NS_CHKR_ST_IDLE;
    endcase
  end

  // Handshake and error outputs, registered from the next state
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      snd0_req  <= 1'b0;
      rcv0_ack  <= 1'b0;
      redun_err <= 1'b0;
    end else begin
      snd0_req  <= (st_q == NS_CHKR_ST_SND) &&
                   (st_n == NS_CHKR_ST_SND);
      rcv0_ack  <= (st_n == NS_CHKR_ST_RLS);
      redun_err <= (st_n == NS_CHKR_ST_DROP);
    end
  end

  // Message buffer, loaded only when a new request is accepted
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      src_q <= '0;
      dst_q <= '0;
      dat_q <= '0;
      red_q <= '0;
    end else if (st_q == NS_CHKR_ST_IDLE && rcv0_req) begin
      src_q <= rcv0_src;
      dst_q <= rcv0_dst;
      dat_q <= rcv0_dat;
      red_q <= rcv0_red;
    end
  end

`ifdef NS_REDUN_ERR_CNT_EN
  // Saturating count of dropped messages
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset)
      err_cnt <= '0;
    else if (drop_ev && (err_cnt != '1))
      err_cnt <= err_cnt + ECSZ'(1);
  end
`else
  logic unused_drop;
  assign unused_drop = drop_ev;
  assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_check_redun.sv
// Directed testbench for check_redun (RSZ=ASZ=DSZ=4).
// Expected err_cnt follows NS_REDUN_ERR_CNT_EN.
module tb_check_redun;

  logic       i_clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rcv0_src = '0;
  logic [3:0] rcv0_dst = '0;
  logic [3:0] rcv0_dat = '0;
  logic [3:0] rcv0_red = '0;
  logic       rcv0_req = 1'b0;
  logic       rcv0_ack;
  logic [3:0] snd0_src;
  logic [3:0] snd0_dst;
  logic [3:0] snd0_dat;
  logic [3:0] snd0_red;
  logic       snd0_req;
  logic       snd0_ack = 1'b0;
  logic       redun_err;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int nbad   = 0;

  check_redun #(
    .RSZ (4), .ASZ (4), .DSZ (4), .ECSZ (8)
  ) dut (
    .i_clk     (i_clk),
    .reset     (reset),
    .rcv0_src  (rcv0_src),
    .rcv0_dst  (rcv0_dst),
    .rcv0_dat  (rcv0_dat),
    .rcv0_red  (rcv0_red),
    .rcv0_req  (rcv0_req),
    .rcv0_ack  (rcv0_ack),
    .snd0_src  (snd0_src),
    .snd0_dst  (snd0_dst),
    .snd0_dat  (snd0_dat),
    .snd0_red  (snd0_red),
    .snd0_req  (snd0_req),
    .snd0_ack  (snd0_ack),
    .redun_err (redun_err),
    .err_cnt   (err_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef NS_REDUN_ERR_CNT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic pick(input int sel);
    case (sel)
      0:       return snd0_req;
      1:       return rcv0_ack;
      default: return redun_err;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val,
                          input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge i_clk);
      if (pick(sel) === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic put(input logic [3:0] s, d, t, r);
    rcv0_src = s;
    rcv0_dst = d;
    rcv0_dat = t;
    rcv0_red = r;
    rcv0_req = 1'b1;
  endtask

  task automatic xfer(input logic [3:0] s, d, t, r,
                      output logic [15:0] got, output bit ok);
    bit o1, o2, o3, o4;
    put(s, d, t, r);
    wait_sig(0, 1'b1, 20, o1);
    got = {snd0_src, snd0_dst, snd0_dat, snd0_red};
    snd0_ack = 1'b1;
    wait_sig(0, 1'b0, 20, o2);
    snd0_ack = 1'b0;
    wait_sig(1, 1'b1, 20, o3);
    rcv0_req = 1'b0;
    wait_sig(1, 1'b0, 20, o4);
    ok = o1 && o2 && o3 && o4;
  endtask

  task automatic send_bad(input logic [3:0] r, output bit ok);
    bit o1, o2;
    put(4'hF, 4'hF, 4'hF, r);
    wait_sig(1, 1'b1, 20, o1);
    rcv0_req = 1'b0;
    wait_sig(1, 1'b0, 20, o2);
    ok = o1 && o2;
    nbad++;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({snd0_req, rcv0_ack, redun_err} !== 3'b000) begin
      errors++;
      $display("FAIL rst_ctl got %b want 000",
               {snd0_req, rcv0_ack, redun_err});
    end
    #2 reset = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({snd0_src, snd0_dst, snd0_dat, snd0_red} !== 16'h0) begin
      errors++;
      $display("FAIL rst_buf got %h want 0000",
               {snd0_src, snd0_dst, snd0_dat, snd0_red});
    end
    checks++;
    if (err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL rst_cnt got %h want 00", err_cnt);
    end
  endtask

  task automatic test_latency;
    bit o1, o2, o3;
    put(4'h0, 4'h0, 4'h0, 4'hF);
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if (snd0_req !== 1'b0) begin
      errors++;
      $display("FAIL lat_early got %b want 0", snd0_req);
    end
    @(negedge i_clk);
    checks++;
    if (snd0_req !== 1'b1) begin
      errors++;
      $display("FAIL lat_n2 got %b want 1", snd0_req);
    end
    checks++;
    if ({snd0_src, snd0_dst, snd0_dat, snd0_red} !== 16'h000F) begin
      errors++;
      $display("FAIL lat_data got %h want 000f",
               {snd0_src, snd0_dst, snd0_dat, snd0_red});
    end
    snd0_ack = 1'b1;
    wait_sig(0, 1'b0, 20, o1);
    snd0_ack = 1'b0;
    wait_sig(1, 1'b1, 20, o2);
    rcv0_req = 1'b0;
    wait_sig(1, 1'b0, 20, o3);
    checks++;
    if (!(o1 && o2 && o3) || err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL lat_hs got ok=%b cnt=%h want ok=1 cnt=00",
               o1 && o2 && o3, err_cnt);
    end
  endtask

  task automatic test_all_ones;
    logic [15:0] got;
    bit ok;
    xfer(4'hF, 4'hF, 4'hF, 4'h0, got, ok);
    checks++;
    if (!ok || got !== 16'hFFF0) begin
      errors++;
      $display("FAIL ones_fwd got ok=%b %h want ok=1 fff0",
               ok, got);
    end
  endtask

  task automatic test_bad;
    int  nerr = 0;
    bit  sndh = 0;
    bit  ackd = 0;
    put(4'hF, 4'hF, 4'hF, 4'h1);
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      if (redun_err) nerr++;
      if (snd0_req) sndh = 1'b1;
      if (rcv0_ack && !ackd) begin
        ackd = 1'b1;
        rcv0_req = 1'b0;
      end
    end
    nbad++;
    checks++;
    if (nerr != 1) begin
      errors++;
      $display("FAIL bad_pulse got %0d cycles want 1", nerr);
    end
    checks++;
    if (sndh || !ackd || rcv0_ack !== 1'b0) begin
      errors++;
      $display("FAIL bad_hs got snd=%b ackd=%b ack=%b want 0 1 0",
               sndh, ackd, rcv0_ack);
    end
    checks++;
    if (err_cnt !== exp_cnt(nbad)) begin
      errors++;
      $display("FAIL bad_cnt got %h want %h",
               err_cnt, exp_cnt(nbad));
    end
  endtask

  task automatic test_backpressure;
    bit o1, o2, o3, o4;
    bit bad = 0;
    logic [15:0] cap;
    put(4'hF, 4'hF, 4'h0, 4'h3);
    wait_sig(0, 1'b1, 20, o1);
    cap = {snd0_src, snd0_dst, snd0_dat, snd0_red};
    repeat (10) begin
      @(negedge i_clk);
      if (snd0_req !== 1'b1 || rcv0_ack !== 1'b0 ||
          {snd0_src, snd0_dst, snd0_dat, snd0_red} !== cap)
        bad = 1'b1;
    end
    checks++;
    if (!o1 || cap !== 16'hFF03) begin
      errors++;
      $display("FAIL bp_data got ok=%b %h want ok=1 ff03",
               o1, cap);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold got unstable want stable");
    end
    snd0_ack = 1'b1;
    wait_sig(0, 1'b0, 20, o2);
    snd0_ack = 1'b0;
    wait_sig(1, 1'b1, 20, o3);
    rcv0_req = 1'b0;
    wait_sig(1, 1'b0, 20, o4);
    checks++;
    if (!(o2 && o3 && o4)) begin
      errors++;
      $display("FAIL bp_hs got 0 want 1");
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ga, gb;
    bit oa, ob;
    xfer(4'hF, 4'hF, 4'h0, 4'h3, ga, oa);
    xfer(4'h1, 4'hF, 4'hF, 4'h8, gb, ob);
    checks++;
    if (!oa || ga !== 16'hFF03) begin
      errors++;
      $display("FAIL b2b_a got ok=%b %h want ok=1 ff03", oa, ga);
    end
    checks++;
    if (!ob || gb !== 16'h1FF8) begin
      errors++;
      $display("FAIL b2b_b got ok=%b %h want ok=1 1ff8", ob, gb);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] got;
    bit o1, ok;
    put(4'h1, 4'hF, 4'hF, 4'h8);
    wait_sig(0, 1'b1, 20, o1);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (!o1 || {snd0_req, rcv0_ack, redun_err} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_ctl got ok=%b %b want ok=1 000",
               o1, {snd0_req, rcv0_ack, redun_err});
    end
    rcv0_req = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({snd0_src, snd0_dst, snd0_dat, snd0_red} !== 16'h0 ||
        err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL rmid_buf got %h cnt=%h want 0000 cnt=00",
               {snd0_src, snd0_dst, snd0_dat, snd0_red}, err_cnt);
    end
    nbad = 0;
    #2 reset = 1'b1;
    @(negedge i_clk);
    xfer(4'hF, 4'hF, 4'h0, 4'h3, got, ok);
    checks++;
    if (!ok || got !== 16'hFF03) begin
      errors++;
      $display("FAIL rmid_after got ok=%b %h want ok=1 ff03",
               ok, got);
    end
  endtask

  task automatic test_err_sat;
    bit ok;
    bit all_ok = 1'b1;
    for (int i = 0; i < 260; i++) begin
      send_bad(4'h1, ok);
      all_ok &= ok;
      if (i == 254) begin
        checks++;
        if (err_cnt !== exp_cnt(nbad)) begin
          errors++;
          $display("FAIL sat_255 got %h want %h",
                   err_cnt, exp_cnt(nbad));
        end
      end
    end
    checks++;
    if (!all_ok || err_cnt !== exp_cnt(nbad)) begin
      errors++;
      $display("FAIL sat_hold got ok=%b %h want ok=1 %h",
               all_ok, err_cnt, exp_cnt(nbad));
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_all_ones();
    test_bad();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_err_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
